// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory fetch port.
//   IMEM_NOP        - instruction returned on a faulting fetch (all zeros)
//   rsp_state_t     - response-slot state (EMPTY / FULL)
//   fetch_err()     - flags a misaligned or out-of-range byte address
package imem_pkg;

  localparam logic [63:0] IMEM_NOP = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  // The byte address is zero-extended to 32 bits by the caller. It is an error
  // if the address is not word aligned or if its word index is past the last word.
  function automatic logic fetch_err(input logic [31:0] byte_pc,
                                     input int unsigned depth);
    return (byte_pc[1:0] != 2'b00) || ((byte_pc >> 2) >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_W storage with one write port and one read port.
// Both ports are synchronous. The read is read-first: a read and a write to the
// same word in one cycle return the old word.
//   clk, reset      - clock; asynchronous active-high reset (clears read register only)
//   we/waddr/wdata  - write strobe, word index, data
//   re/raddr        - read strobe, word index
//   rdata           - registered read data; it holds its value while re is low
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left without a reset so it maps onto
  // RAM. Only the read register is reset, so a cleared response reads as zero.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking assignments give read-first behaviour. The read samples
  // the word as it was before this edge's write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: clocked instruction memory with a valid/ready fetch port and
// a run-time word loader. The response is registered and held under back-pressure.
// Faulting fetches (misaligned or out of range) return IMEM_NOP with rsp_err set.
//   clk, reset                 - clock; asynchronous active-high reset
//   ld_en/ld_addr/ld_data      - loader write (indices >= DEPTH are dropped)
//   req_valid/req_ready/req_pc - fetch request, byte address
//   rsp_valid/rsp_ready        - response handshake
//   rsp_instr/rsp_err          - fetched word and fault flag
// Optional build macro IMEM_LOAD_LOCK_EN adds the ld_lock input. A pulse on
// ld_lock blocks all later loader writes until reset.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
`ifdef IMEM_LOAD_LOCK_EN
  input  logic              ld_lock,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W+1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err
);

  rsp_state_t        state;
  logic              accept;
  logic              req_err;
  logic              lock_q;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign req_err   = fetch_err(32'(req_pc), DEPTH);

  // The lock is a register, so a write in the same cycle as the lock pulse still lands.
  assign wr_en = ld_en && (32'(ld_addr) < DEPTH) && !lock_q;

`ifdef IMEM_LOAD_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        lock_q <= 1'b0;
    else if (ld_lock) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

  // A faulting fetch skips the array read. Its index may lie outside the array,
  // and the output mux hides the stale read data anyway.
  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (accept && !req_err),
    .raddr (req_pc[ADDR_W+1:2]),
    .rdata (rd_data)
  );

  // Both mux inputs come from registers, so rsp_instr changes only on an accept or a reset.
  assign rsp_instr = rsp_err ? DATA_W'(IMEM_NOP) : rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state     <= FULL;
          rsp_valid <= 1'b1;
          rsp_err   <= req_err;
        end
        FULL: if (accept) begin
          rsp_err   <= req_err;
        end else if (rsp_ready) begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: directed self-checking bench for imem_fetch_port.
// The main instance uses the default 16-word build. A second 12-word instance
// covers the out-of-range fault. Inputs change 1 time unit after a rising edge,
// and outputs are sampled at that same point.
module tb_imem_fetch_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_lock;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  logic        s_req_valid;
  logic        s_req_ready;
  logic [5:0]  s_req_pc;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_instr;
  logic        s_rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_port #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
`ifdef IMEM_LOAD_LOCK_EN
    .ld_lock   (ld_lock),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err)
  );

  imem_fetch_port #(.DATA_W(32), .DEPTH(12), .ADDR_W(4)) dut_small (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (1'b0),
    .ld_addr   (4'd0),
    .ld_data   (32'd0),
`ifdef IMEM_LOAD_LOCK_EN
    .ld_lock   (1'b0),
`endif
    .req_valid (s_req_valid),
    .req_ready (s_req_ready),
    .req_pc    (s_req_pc),
    .rsp_valid (s_rsp_valid),
    .rsp_ready (1'b1),
    .rsp_instr (s_rsp_instr),
    .rsp_err   (s_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_lock = 1'b0;
    req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_pc = '0;
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_instr", rsp_instr, 0);
    check("reset_rsp_err",   rsp_err,   0);
    check("reset_req_ready", req_ready, 1);
    tick(); tick();
    reset = 1'b0;

    // Load words 0..15.
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = 32'h1000_0000 + i;
      tick();
    end
    ld_en = 1'b0;

    // Back-to-back fetches with rsp_ready held high: one response per cycle.
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_pc = 6'(i * 4);
      tick();
      check($sformatf("b2b_valid_%0d", i), rsp_valid, 1);
      check($sformatf("b2b_instr_%0d", i), rsp_instr, 32'h1000_0000 + i);
      check($sformatf("b2b_err_%0d", i),   rsp_err,   0);
    end
    req_valid = 1'b0;
    tick();
    check("drain_rsp_valid", rsp_valid, 0);

    // Back-pressure: the response must hold, even across a write to the same word.
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 6'h08;
    tick();
    check("bp_first_instr", rsp_instr, 32'h1000_0002);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'hDEAD_BEEF; end
      else ld_en = 1'b0;
      check($sformatf("bp_req_ready_%0d", k), req_ready, 0);
      tick();
      check($sformatf("bp_valid_%0d", k), rsp_valid, 1);
      check($sformatf("bp_instr_%0d", k), rsp_instr, 32'h1000_0002);
    end
    ld_en = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", req_ready, 1);
    tick();
    check("bp_refetch_instr", rsp_instr, 32'hDEAD_BEEF);
    check("bp_refetch_err",   rsp_err,   0);

    // Misaligned fetch, plus out-of-range fetch on the 12-word instance.
    req_pc = 6'h06;
    s_req_valid = 1'b1; s_req_pc = 6'h30;
    tick();
    check("misalign_valid", rsp_valid, 1);
    check("misalign_instr", rsp_instr, 0);
    check("misalign_err",   rsp_err,   1);
    check("range_valid", s_rsp_valid, 1);
    check("range_instr", s_rsp_instr, 0);
    check("range_err",   s_rsp_err,   1);
    s_req_pc = 6'h2C;
    tick();
    check("range_last_word_err", s_rsp_err, 0);
    s_req_valid = 1'b0;

    // Same-cycle load and fetch of word 5: read-first.
    req_pc = 6'h14; ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'hAAAA_5555;
    tick();
    ld_en = 1'b0;
    check("collide_old_instr", rsp_instr, 32'h1000_0005);
    tick();
    check("collide_new_instr", rsp_instr, 32'hAAAA_5555);

    // Reset mid-transaction while a response is pending.
    req_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    check("pre_reset_valid", rsp_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("midreset_valid", rsp_valid, 0);
    check("midreset_instr", rsp_instr, 0);
    check("midreset_err",   rsp_err,   0);
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 6'h0C;
    tick();
    check("persist_word3", rsp_instr, 32'h1000_0003);
    req_pc = 6'h14;
    tick();
    check("persist_word5", rsp_instr, 32'hAAAA_5555);
    req_valid = 1'b0;
    tick();

`ifdef IMEM_LOAD_LOCK_EN
    // Lock, then a write to word 0 must be ignored until reset.
    ld_lock = 1'b1;
    tick();
    ld_lock = 1'b0;
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 32'h1234_5678;
    tick();
    ld_en = 1'b0; req_valid = 1'b1; req_pc = 6'h00;
    tick();
    check("lock_blocks_write", rsp_instr, 32'h1000_0000);
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0; req_valid = 1'b1;
    tick();
    check("unlock_after_reset", rsp_instr, 32'h1234_5678);
    req_valid = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
